// File: rtl/store_packer.sv
// store_packer: registered MEM-stage store path.
// Packs a register value into little-endian byte lanes with byte enables.
// Flags misaligned and reserved-size accesses. Output goes through a
// one-entry skid buffer on a valid/ready handshake.
// Optional macro STORE_TRUNC_CHECK_EN: computes out_trunc (value does not
// fit the narrowed width) at accept time and carries it with the entry.
module store_packer (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  input  logic [31:0] in_addr,
  input  logic [1:0]  in_size,
  input  logic        in_signed,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_addr,
  output logic [31:0] out_wdata,
  output logic [3:0]  out_be,
  output logic        out_err,
  output logic        out_trunc
);

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        err;
`ifdef STORE_TRUNC_CHECK_EN
    logic        trunc;
`endif
  } entry_t;

  // Bit 0 is "output register valid", bit 1 is "skid valid", so out_valid
  // comes straight off a state flop.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    FULL1 = 2'b01,
    FULL2 = 2'b11
  } state_t;

  state_t state_q, state_d;
  entry_t out_q, out_d;
  entry_t skid_q, skid_d;
  logic   in_ready_q, in_ready_d;
  entry_t pk;
  logic   accept, drain;

  assign accept = in_valid && in_ready_q;
  assign drain  = state_q[0] && out_ready;

  // Pack the incoming request into lane-positioned data and byte enables.
  always_comb begin
    pk       = '0;
    pk.addr  = {in_addr[31:2], 2'b00};
    pk.wdata = in_data;
    case (in_size)
      2'b00: begin
        pk.wdata = {4{in_data[7:0]}};
        pk.be    = 4'b0001 << in_addr[1:0];
      end
      2'b01: begin
        pk.wdata = {2{in_data[15:0]}};
        pk.be    = in_addr[1] ? 4'b1100 : 4'b0011;
        pk.err   = in_addr[0];
      end
      2'b10: begin
        pk.be    = 4'b1111;
        pk.err   = |in_addr[1:0];
      end
      default: pk.err = 1'b1;
    endcase
    if (pk.err) pk.be = 4'b0000;
`ifdef STORE_TRUNC_CHECK_EN
    // Signed: upper bits must all equal the narrowed sign bit.
    // Unsigned: upper bits must be zero. Word/errored accesses never truncate.
    case (in_size)
      2'b00: pk.trunc = in_signed ? !((&in_data[31:7]) || !(|in_data[31:7]))
                                  : |in_data[31:8];
      2'b01: pk.trunc = in_signed ? !((&in_data[31:15]) || !(|in_data[31:15]))
                                  : |in_data[31:16];
      default: pk.trunc = 1'b0;
    endcase
    if (pk.err) pk.trunc = 1'b0;
`endif
  end

`ifndef STORE_TRUNC_CHECK_EN
  // Signedness only matters to the range check.
  logic unused_in_signed;
  assign unused_in_signed = in_signed;
`endif

  // Next-state: route accepts to output reg or skid, refill output from skid on drain.
  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    skid_d  = skid_q;
    case (state_q)
      EMPTY: begin
        if (accept) begin
          out_d   = pk;
          state_d = FULL1;
        end
      end
      FULL1: begin
        if (accept && drain) begin
          out_d = pk;
        end else if (accept) begin
          skid_d  = pk;
          state_d = FULL2;
        end else if (drain) begin
          state_d = EMPTY;
        end
      end
      FULL2: begin
        if (drain) begin
          out_d   = skid_q;
          state_d = FULL1;
        end
      end
      default: state_d = EMPTY;
    endcase
    in_ready_d = (state_d != FULL2);
  end

  // State, output and skid registers; reset discards everything in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= EMPTY;
      out_q      <= '0;
      skid_q     <= '0;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      out_q      <= out_d;
      skid_q     <= skid_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = state_q[0];
  assign out_addr  = out_q.addr;
  assign out_wdata = out_q.wdata;
  assign out_be    = out_q.be;
  assign out_err   = out_q.err;
`ifdef STORE_TRUNC_CHECK_EN
  assign out_trunc = out_q.trunc;
`else
  assign out_trunc = 1'b0;
`endif

endmodule

// File: tb/tb_store_packer.sv
// Scoreboard bench for store_packer: accepted requests push the reference
// result, a negedge monitor pops and compares on every drain.
module tb_store_packer;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, in_signed;
  logic [31:0] in_data, in_addr;
  logic [1:0]  in_size;
  logic        out_valid, out_ready;
  logic [31:0] out_addr, out_wdata;
  logic [3:0]  out_be;
  logic        out_err, out_trunc;

  store_packer dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_addr(in_addr), .in_size(in_size), .in_signed(in_signed),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_addr(out_addr), .out_wdata(out_wdata), .out_be(out_be),
    .out_err(out_err), .out_trunc(out_trunc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        err;
    logic        trunc;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   ndrain = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: lane replication by multiplication, enables by shifting a
  // lane mask, range check by comparing the integer value against limits.
  function automatic exp_t model(input logic [31:0] d, input logic [31:0] a,
                                 input logic [1:0] sz, input logic sgn);
    exp_t e;
`ifdef STORE_TRUNC_CHECK_EN
    longint v, lim;
`endif
    e.addr  = a & 32'hFFFF_FFFC;
    e.err   = 1'b0;
    e.trunc = 1'b0;
    case (sz)
      2'd0: begin e.wdata = d[7:0] * 32'h0101_0101; e.be = 4'b0001 << (a % 4); end
      2'd1: begin e.wdata = d[15:0] * 32'h0001_0001; e.be = 4'b0011 << (2 * ((a / 2) % 2));
                  e.err = (a % 2) != 0; end
      2'd2: begin e.wdata = d; e.be = 4'b1111; e.err = (a % 4) != 0; end
      default: begin e.wdata = d; e.be = 4'b0000; e.err = 1'b1; end
    endcase
    if (e.err) e.be = 4'b0000;
`ifdef STORE_TRUNC_CHECK_EN
    if (!e.err && sz < 2) begin
      lim = (sz == 0) ? 128 : 32768;
      if (sgn) begin v = longint'($signed(d)); e.trunc = (v < -lim) || (v >= lim); end
      else begin v = longint'(d); e.trunc = v >= 2 * lim; end
    end
`else
    if (sgn === 1'bx) e.trunc = 1'b0;
`endif
    return e;
  endfunction

  // Monitor / scoreboard, sampled mid-cycle.
  logic        hold_chk = 1'b0;
  logic [31:0] h_addr, h_wdata;
  logic [3:0]  h_be;
  logic        h_err, h_trunc;
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      q.delete();
      hold_chk = 1'b0;
    end else begin
      if (hold_chk) begin
        chk("hold_addr", out_addr, h_addr);
        chk("hold_wdata", out_wdata, h_wdata);
        chk("hold_be_err_trunc", {out_be, out_err, out_trunc}, {h_be, h_err, h_trunc});
      end
      if (out_valid && out_ready) begin
        ndrain++;
        if (q.size() == 0) begin
          chk("sb_unexpected_output", 32'(q.size()), 32'd1);
        end else begin
          e = q.pop_front();
          chk("sb_addr", out_addr, e.addr);
          chk("sb_wdata", out_wdata, e.wdata);
          chk("sb_be", out_be, e.be);
          chk("sb_err", out_err, e.err);
          chk("sb_trunc", out_trunc, e.trunc);
        end
      end
      if (in_valid && in_ready) q.push_back(model(in_data, in_addr, in_size, in_signed));
      hold_chk = out_valid && !out_ready;
      h_addr = out_addr; h_wdata = out_wdata; h_be = out_be; h_err = out_err; h_trunc = out_trunc;
    end
  end

  // Present a request and hold it until accepted (bounded).
  task automatic send(input logic [31:0] d, input logic [31:0] a,
                      input logic [1:0] sz, input logic sgn);
    in_valid = 1'b1; in_data = d; in_addr = a; in_size = sz; in_signed = sgn;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk); #1;
        in_valid = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    n_cmp++; n_bad++;
    $display("FAIL send_timeout: got no accept expected accept within 20 cycles");
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic chk_cleared(input string nm);
    chk({nm, "_out_valid"}, out_valid, 1'b0);
    chk({nm, "_in_ready"}, in_ready, 1'b1);
    chk({nm, "_addr"}, out_addr, 32'h0);
    chk({nm, "_wdata"}, out_wdata, 32'h0);
    chk({nm, "_be_err_trunc"}, {out_be, out_err, out_trunc}, 6'b0);
  endtask

  int d0;

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_addr = '0; in_size = '0;
    in_signed = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_cleared("reset");
    rst = 1'b0;
    idle(1);

    // Directed stores, free-flowing output.
    out_ready = 1'b1;
    send(32'h0000_00AB, 32'h0000_1003, 2'd0, 1'b0);
    send(32'h0000_1234, 32'h0000_2002, 2'd1, 1'b0);
    send(32'hDEAD_BEEF, 32'h0000_2001, 2'd2, 1'b0);
    send(32'h5555_AAAA, 32'h0000_3001, 2'd1, 1'b0);
    send(32'h0BAD_F00D, 32'h0000_4000, 2'd3, 1'b0);
    send(32'h0000_0080, 32'h0000_5000, 2'd0, 1'b1);
    send(32'hFFFF_FF80, 32'h0000_5001, 2'd0, 1'b1);
    send(32'h0001_0000, 32'h0000_5002, 2'd1, 1'b0);
    send(32'hFFFF_8000, 32'h0000_5000, 2'd1, 1'b1);
    send(32'h0000_0100, 32'h0000_5002, 2'd0, 1'b0);
    idle(3);

    // Back-pressure: two accepted, third stalls until the skid drains.
    out_ready = 1'b0;
    send(32'h11, 32'h0000_6000, 2'd2, 1'b0);
    send(32'h22, 32'h0000_6004, 2'd2, 1'b0);
    in_valid = 1'b1; in_data = 32'h33; in_addr = 32'h0000_6008; in_size = 2'd2;
    @(negedge clk);
    chk("bp_in_ready_low", in_ready, 1'b0);
    chk("bp_out_valid", out_valid, 1'b1);
    @(posedge clk); #1;
    out_ready = 1'b1;
    d0 = ndrain;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_no_gap", out_valid, 1'b1);
      @(posedge clk); #1;
      if (i == 1) in_valid = 1'b0;
    end
    chk("bp_drain_count", 32'(ndrain - d0), 32'd3);
    idle(2);

    // Accept and drain together: one transfer per cycle, skid never used.
    d0 = ndrain;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; in_data = $urandom; in_addr = $urandom & 32'hFFFF_FFFC; in_size = 2'd2;
      @(negedge clk);
      chk("tput_in_ready", in_ready, 1'b1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    idle(1);
    chk("tput_drain_count", 32'(ndrain - d0), 32'd10);

    // Reset while FULL2, with a request offered in the reset cycle.
    out_ready = 1'b0;
    send(32'hA1, 32'h0000_7000, 2'd2, 1'b0);
    send(32'hA2, 32'h0000_7004, 2'd2, 1'b0);
    in_valid = 1'b1; in_data = 32'hA3; in_addr = 32'h0000_7008; in_size = 2'd2;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0;
    chk_cleared("midrst");
    d0 = ndrain;
    out_ready = 1'b1;
    send(32'hCAFE_F00D, 32'h0000_8004, 2'd2, 1'b0);
    idle(3);
    chk("midrst_single_out", 32'(ndrain - d0), 32'd1);

    // Randomized traffic with random back-pressure.
    for (int i = 0; i < 600; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      case ($urandom_range(0, 3))
        0: in_data = $urandom_range(0, 255);
        1: in_data = 32'hFFFF_FF00 | $urandom_range(0, 255);
        2: in_data = $urandom_range(0, 65535) | ($urandom_range(0, 1) << 16);
        default: in_data = $urandom;
      endcase
      in_addr   = $urandom;
      in_size   = 2'($urandom_range(0, 3));
      in_signed = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 10 && q.size() != 0; i++) idle(1);
    idle(1);
    chk("final_queue_empty", 32'(q.size()), 32'd0);
    chk("final_out_valid", out_valid, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/store_packer.md
# store_packer

Registered MEM-stage store path for the pipelined datapath: the write-side counterpart of the load/immediate sign-extension path. Accepts a 32-bit register value plus byte address and access size. Emits a word-aligned address, lane-shifted write data and byte enables toward data memory over a valid/ready handshake, with a one-entry skid buffer so back-pressure never drops a store. Flags misaligned or reserved-size accesses, and optionally flags values that do not fit the narrowed width.

## Interface

Parameters: none (width fixed at 32-bit data, 32-bit address).

Ports:
- `clk` — input — 1 — rising-edge clock.
- `rst` — input — 1 — one clock; reset is synchronous and active-high.
- `in_valid` — input — 1 — store request present.
- `in_ready` — output — 1 — block can accept a request this cycle.
- `in_data` — input — 32 — register value; low bits hold the stored quantity.
- `in_addr` — input — 32 — byte address.
- `in_size` — input — 2 — access size: 00 byte, 01 halfword, 10 word, 11 reserved.
- `in_signed` — input — 1 — range check treats value as signed (used only with the macro).
- `out_valid` — output — 1 — packed store present.
- `out_ready` — input — 1 — memory accepts the store.
- `out_addr` — output — 32 — word address `{in_addr[31:2],2'b00}`.
- `out_wdata` — output — 32 — lane-positioned data.
- `out_be` — output — 4 — byte enables; bit i covers `out_wdata[8i+7:8i]`.
- `out_err` — output — 1 — misaligned or reserved size; `out_be` is 0000 when set.
- `out_trunc` — output — 1 — value exceeds the narrowed width (see Configuration).

## Operation

- Little-endian lanes: byte lane = `addr[1:0]`; halfword lane = `addr[1]`.
- Byte store: `out_wdata = {4{in_data[7:0]}}`; `out_be = 1 << addr[1:0]`.
- Halfword store: `out_wdata = {2{in_data[15:0]}}`; `out_be = addr[1] ? 1100 : 0011`.
  - If `addr[0]=1`: `out_err=1`, `out_be=0000`.
- Word store: `out_wdata = in_data`; `out_be = 1111`.
  - If `addr[1:0]!=0`: `out_err=1`, `out_be=0000`.
- Reserved size 11: `out_err=1`, `out_be=0000`, `out_wdata=in_data`.
- Errored stores still handshake normally (pass through as one transfer); the downstream stage raises the exception.
- Storage:
  - Output register (`out_*`).
  - One skid entry holding the same fields plus a skid-valid bit.
- Accept: `in_valid && in_ready`.
  - Goes to the output register if it is empty or being drained this cycle and the skid is empty.
  - Otherwise goes to the skid.
- Drain: `out_valid && out_ready`.
  - If skid is full, skid moves to the output register that edge and the skid empties.
- Order is strictly preserved; no request is lost or duplicated.
- States (implied by out_valid/skid-valid):
  - EMPTY (0,0) → FULL1 on accept.
  - FULL1 (1,0):
    - accept without drain → FULL2;
    - drain without accept → EMPTY;
    - accept with drain → FULL1.
  - FULL2 (1,1): drain → FULL1 (accept impossible, `in_ready=0`).

## Timing

- Latency: accepted request appears on `out_*` the next cycle when EMPTY or FULL1-draining.
- Sustained throughput: one store per cycle while `out_ready=1`.
- `in_ready` is a register, equal to NOT skid-valid.
  - Drops the cycle after the skid fills.
  - Rises the cycle after the skid drains.
- `out_*` are driven straight from registers; no combinational path from `in_*` to `out_*`.
- `out_*` hold stable while `out_valid && !out_ready`.
- Reset (any cycle, including mid-transfer) clears all stored state:
  - `out_valid=0`, `in_ready=1`.
  - `out_addr`, `out_wdata` = 0; `out_be=0000`; `out_err=0`; `out_trunc=0`.
  - Skid emptied.
  - Pending stores are discarded.
  - No input is accepted in the reset cycle.

## Configuration

- Macro: `STORE_TRUNC_CHECK_EN`.
- Defined: `out_trunc` is computed at accept and registered with the entry.
  - Byte, signed: set when `in_data[31:7]` is not all-equal.
  - Byte, unsigned: set when `in_data[31:8]!=0`.
  - Halfword: same rule, using bit 15 / bits 31:16.
  - Word, reserved size, or errored access: always 0.
- Undefined: `out_trunc` is tied to 0; no check logic or skid storage for it.

## Test plan

- Byte store, `in_data=0x000000AB`, `addr=0x1003`, `out_ready=1` → next cycle `out_addr=0x1000`, `out_wdata=0xABABABAB`, `out_be=1000`, `out_err=0`.
- Halfword `0x00001234` at `0x2002`, then word `0xDEADBEEF` at `0x2001` on back-to-back cycles:
  - first → `out_be=1100`, `out_wdata=0x12341234`;
  - second → `out_be=0000`, `out_err=1`.
- Back-pressure: `out_ready=0`, three consecutive valid words `0x11`, `0x22`, `0x33`.
  - First two accepted; `in_ready=0` from cycle 3.
  - Raise `out_ready` → outputs 0x11, 0x22, 0x33 in order, no gaps.
- Simultaneous accept and drain in FULL1 for 10 cycles → every cycle transfers; skid never fills.
- With `STORE_TRUNC_CHECK_EN`, signed byte stores:
  - `0x00000080` → `out_trunc=1`;
  - `0xFFFFFF80` → 0.
  - Unsigned halfword `0x00010000` → 1.
- Reset asserted in FULL2 → next cycle `out_valid=0`, `in_ready=1`, all outputs 0; the following accepted store emerges alone.
